papuf_vote_ctrl: RTL and testbench

PAPUF_VOTE_CTRL -- requirements
Module: papuf_vote_ctrl

---
 rtl/papuf_pkg.sv | 24 ++
 rtl/papuf_vote_ctrl_if.sv | 27 ++
 rtl/papuf_array.sv | 24 ++
 rtl/papuf_vote_ctrl.sv | 177 +++++++++++++++++
 tb/tb_papuf_vote_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/papuf_pkg.sv
// Shared definitions for the PUF majority-vote controller: FSM state
// encoding, default parameter values and the behavioural cell skew pattern.
package papuf_pkg;

  localparam int CW_DEF         = 16;
  localparam int RW_DEF         = 16;
  localparam int NEVAL_DEF      = 5;
  localparam int SETTLE_CYC_DEF = 2;
  localparam int PULSE_CYC_DEF  = 2;
  localparam int CAP_CYC_DEF    = 4;

  // Per-cell static delay bias of the behavioural arbiter model (bit i of
  // the pattern is the bias of cell i, repeating every 16 cells).
  localparam logic [15:0] ARB_SKEW = 16'hA5A5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_PULSE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/papuf_vote_ctrl_if.sv
// Challenge/response handshake bundle between a requester (master) and the
// vote controller (slave).
interface papuf_vote_ctrl_if #(
  parameter int CW = 16,
  parameter int RW = 16
);

  logic          chal_valid;
  logic          chal_ready;
  logic [CW-1:0] chal_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [RW-1:0] resp_data;
  logic [RW-1:0] resp_unstable;
  logic          busy;

  modport master (
    output chal_valid, chal_data, resp_ready,
    input  chal_ready, resp_valid, resp_data, resp_unstable, busy
  );

  modport slave (
    input  chal_valid, chal_data, resp_ready,
    output chal_ready, resp_valid, resp_data, resp_unstable, busy
  );

endinterface

// File: rtl/papuf_array.sv
// RW single-bit arbiter cells sharing one challenge bus. This body is the
// behavioural stand-in; silicon swaps in the hard arbiter macro per cell.
module papuf_array
  import papuf_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [CW-1:0] challenge,
  input  logic          pulse,
  output logic [RW-1:0] response
);

  // The behavioural cell resolves instantly, so the race pulse is not needed.
  logic unused_pulse;
  assign unused_pulse = pulse;

  for (genvar i = 0; i < RW; i++) begin : g_cell
    localparam int SEL = i % CW;
    localparam int SKW = i % 16;
    assign response[i] = challenge[SEL] ^ ARB_SKEW[SKW];
  end

endmodule

// File: rtl/papuf_vote_ctrl.sv
// Evaluates the PUF array NEVAL times per challenge, tallies each
// synchronized response bit and presents the majority vote plus disagreement flags.
module papuf_vote_ctrl
  import papuf_pkg::*;
#(
  parameter int CW         = CW_DEF,
  parameter int RW         = RW_DEF,
  parameter int NEVAL      = NEVAL_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int PULSE_CYC  = PULSE_CYC_DEF,
  parameter int CAP_CYC    = CAP_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  papuf_vote_ctrl_if.slave bus
);

  localparam int TW     = $clog2(NEVAL + 1);
  localparam int ECW    = (NEVAL > 1) ? $clog2(NEVAL) : 1;
  localparam int MAX_SP = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
  localparam int MAX_PH = (MAX_SP > CAP_CYC) ? MAX_SP : CAP_CYC;
  localparam int PW     = $clog2(MAX_PH + 1);

  localparam logic [PW-1:0]  SETTLE_LAST = PW'(SETTLE_CYC - 1);
  localparam logic [PW-1:0]  PULSE_LAST  = PW'(PULSE_CYC - 1);
  localparam logic [PW-1:0]  CAP_LAST    = PW'(CAP_CYC - 1);
  localparam logic [ECW-1:0] EVAL_LAST   = ECW'(NEVAL - 1);
  localparam logic [TW-1:0]  TALLY_MAX   = TW'(NEVAL);
  localparam logic [TW-1:0]  TALLY_HALF  = TW'(NEVAL / 2);

  state_e                 state_q, state_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [ECW-1:0]         eval_q, eval_d;
  logic [CW-1:0]          chal_q, chal_d;
  logic [RW-1:0][TW-1:0]  tally_q, tally_d;
  logic [RW-1:0][TW-1:0]  tally_inc;
  logic [RW-1:0]          vote_bits, mixed_bits;
  logic [RW-1:0]          resp_data_q, resp_data_d;
  logic [RW-1:0]          unstable_q, unstable_d;
  logic                   chal_ready_q, chal_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   busy_q, busy_d;
  logic                   pulse_q, pulse_d;
  logic [RW-1:0]          sync1_q, sync2_q;

  logic [CW-1:0]          arr_chal;
  logic [RW-1:0]          arr_resp;

  // The array only sees the challenge while an evaluation is running.
  assign arr_chal = busy_q ? chal_q : '0;

  papuf_array #(
    .CW (CW),
    .RW (RW)
  ) u_array (
    .challenge (arr_chal),
    .pulse     (pulse_q),
    .response  (arr_resp)
  );

  // Saturating increment keeps a tally from wrapping even if NEVAL is reached.
  always_comb begin
    for (int i = 0; i < RW; i++) begin
      tally_inc[i]  = (sync2_q[i] && (tally_q[i] != TALLY_MAX)) ? tally_q[i] + TW'(1) : tally_q[i];
      vote_bits[i]  = (tally_inc[i] > TALLY_HALF);
      mixed_bits[i] = (tally_inc[i] != '0) && (tally_inc[i] != TALLY_MAX);
    end
  end

  always_comb begin
    // NOTE: every _d takes its hold value first so no branch can infer a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    eval_d      = eval_q;
    chal_d      = chal_q;
    tally_d     = tally_q;
    resp_data_d = resp_data_q;
    unstable_d  = unstable_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.chal_valid && chal_ready_q) begin
          chal_d  = bus.chal_data;
          tally_d = '0;
          eval_d  = '0;
          phase_d = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (phase_q == SETTLE_LAST) begin
          phase_d = '0;
          state_d = ST_PULSE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_PULSE: begin
        if (phase_q == PULSE_LAST) begin
          phase_d = '0;
          state_d = ST_CAPTURE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_CAPTURE: begin
        if (phase_q == CAP_LAST) begin
          phase_d = '0;
          tally_d = tally_inc;
          if (eval_q < EVAL_LAST) begin
            eval_d  = eval_q + ECW'(1);
            state_d = ST_SETTLE;
          end else begin
            // The vote uses the tally including this final sample.
            resp_data_d = vote_bits;
            unstable_d  = mixed_bits;
            state_d     = ST_DONE;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_DONE: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    chal_ready_d = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_DONE);
    pulse_d      = (state_d == ST_PULSE);
    busy_d       = (state_d == ST_SETTLE) || (state_d == ST_PULSE) || (state_d == ST_CAPTURE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      eval_q       <= '0;
      chal_q       <= '0;
      // NOTE: the tally bank is plain flops, so it is cleared by reset like any other state.
      tally_q      <= '0;
      resp_data_q  <= '0;
      unstable_q   <= '0;
      chal_ready_q <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      pulse_q      <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      eval_q       <= eval_d;
      chal_q       <= chal_d;
      tally_q      <= tally_d;
      resp_data_q  <= resp_data_d;
      unstable_q   <= unstable_d;
      chal_ready_q <= chal_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      pulse_q      <= pulse_d;
      sync1_q      <= arr_resp;
      sync2_q      <= sync1_q;
    end
  end

  assign bus.chal_ready    = chal_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_unstable = unstable_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_papuf_vote_ctrl.sv
// Directed + randomized bench for papuf_vote_ctrl: default configuration and a
// single-evaluation configuration, checked against a counting vote model.
module tb_papuf_vote_ctrl;

  localparam int NEV = 5;
  localparam int S   = 2;
  localparam int P   = 2;
  localparam int C   = 4;
  localparam int T   = S + P + C;
  localparam int L   = NEV * T;
  localparam int L1  = 1 + 1 + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ev [NEV];
  logic [15:0] force_val;
  logic [15:0] force_val1;

  papuf_vote_ctrl_if #(.CW(16), .RW(16)) bus ();
  papuf_vote_ctrl_if #(.CW(16), .RW(16)) bus1 ();

  papuf_vote_ctrl #(
    .CW(16), .RW(16), .NEVAL(NEV), .SETTLE_CYC(S), .PULSE_CYC(P), .CAP_CYC(C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  papuf_vote_ctrl #(
    .CW(16), .RW(16), .NEVAL(1), .SETTLE_CYC(1), .PULSE_CYC(1), .CAP_CYC(3)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Majority vote by counting ones per bit position across evaluations.
  function automatic void vote_model(input logic [15:0] v [NEV],
                                     output logic [15:0] d, output logic [15:0] u);
    for (int i = 0; i < 16; i++) begin
      int ones = 0;
      for (int k = 0; k < NEV; k++) ones += int'(v[k][i]);
      d[i] = (2 * ones > NEV);
      u[i] = (ones != 0) && (ones != NEV);
    end
  endfunction

  task automatic run_main(input logic [15:0] ch, input bit noisy, input int hold,
                          input bit ready_tied, input bit poke, input string tag);
    logic [15:0] v [NEV];
    logic [15:0] exp_d, exp_u;
    int c;
    bit got;
    for (int k = 0; k < NEV; k++) v[k] = noisy ? ev[k] : (ch ^ 16'hA5A5);
    vote_model(v, exp_d, exp_u);
    bus.resp_ready = ready_tied;
    check({tag, "/chal_ready_idle"}, bus.chal_ready, 1);
    bus.chal_valid = 1'b1;
    bus.chal_data  = ch;
    @(posedge clk); #1;
    bus.chal_valid = 1'b0;
    bus.chal_data  = 16'($urandom);
    c   = 0;
    got = 1'b0;
    while (c <= L + 20) begin
      if (noisy && (c % T == 0) && (c / T < NEV)) begin
        force_val = v[c / T];
        force dut.arr_resp = force_val;
      end
      if (poke) bus.chal_valid = (c == 9);
      if (bus.resp_valid) begin
        got = 1'b1;
        break;
      end
      check({tag, "/busy"}, bus.busy, c < L);
      check({tag, "/pulse"}, dut.pulse_q, ((c % T) >= S) && ((c % T) < S + P));
      @(posedge clk); #1;
      c++;
    end
    bus.chal_valid = 1'b0;
    if (noisy) release dut.arr_resp;
    check({tag, "/timeout"}, got, 1);
    check({tag, "/latency"}, c, L);
    check({tag, "/resp_data"}, bus.resp_data, exp_d);
    check({tag, "/resp_unstable"}, bus.resp_unstable, exp_u);
    check({tag, "/chal_ready_done"}, bus.chal_ready, 0);
    check({tag, "/busy_done"}, bus.busy, 0);
    for (int h = 0; h < hold; h++) begin
      bus.chal_valid = (h == 3);
      bus.chal_data  = 16'($urandom);
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, bus.resp_valid, 1);
      check({tag, "/hold_data"}, bus.resp_data, exp_d);
      check({tag, "/hold_unstable"}, bus.resp_unstable, exp_u);
      check({tag, "/hold_chal_ready"}, bus.chal_ready, 0);
      check({tag, "/hold_busy"}, bus.busy, 0);
    end
    bus.chal_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = ready_tied;
    check({tag, "/valid_after_hs"}, bus.resp_valid, 0);
    check({tag, "/ready_after_hs"}, bus.chal_ready, 1);
  endtask

  task automatic run_one(input logic [15:0] ch, input bit noisy, input string tag);
    logic [15:0] exp_d;
    int c;
    bit got;
    exp_d = noisy ? 16'($urandom) : (ch ^ 16'hA5A5);
    bus1.resp_ready = 1'b0;
    check({tag, "/chal_ready_idle"}, bus1.chal_ready, 1);
    bus1.chal_valid = 1'b1;
    bus1.chal_data  = ch;
    @(posedge clk); #1;
    bus1.chal_valid = 1'b0;
    if (noisy) begin
      force_val1 = exp_d;
      force dut1.arr_resp = force_val1;
    end
    c   = 0;
    got = 1'b0;
    while (c <= 30) begin
      if (bus1.resp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    if (noisy) release dut1.arr_resp;
    check({tag, "/timeout"}, got, 1);
    check({tag, "/latency"}, c, L1);
    check({tag, "/resp_data"}, bus1.resp_data, exp_d);
    check({tag, "/resp_unstable"}, bus1.resp_unstable, 16'h0000);
    bus1.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.resp_ready = 1'b0;
    check({tag, "/valid_after_hs"}, bus1.resp_valid, 0);
    check({tag, "/ready_after_hs"}, bus1.chal_ready, 1);
  endtask

  initial begin
    logic [15:0] base;
    bit any_valid;

    bus.chal_valid  = 1'b0;
    bus.chal_data   = '0;
    bus.resp_ready  = 1'b0;
    bus1.chal_valid = 1'b0;
    bus1.chal_data  = '0;
    bus1.resp_ready = 1'b0;

    // Reset state while rst_n is held low.
    repeat (3) @(posedge clk);
    #1;
    check("rst/chal_ready", bus.chal_ready, 1);
    check("rst/resp_valid", bus.resp_valid, 0);
    check("rst/busy", bus.busy, 0);
    check("rst/resp_data", bus.resp_data, 16'h0000);
    check("rst/resp_unstable", bus.resp_unstable, 16'h0000);
    check("rst/pulse", dut.pulse_q, 0);
    check("rst1/resp_valid", bus1.resp_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst/chal_ready_release", bus.chal_ready, 1);

    // Stable array: 0x1234 votes to 0x1234 ^ 0xA5A5 with no unstable bits.
    run_main(16'h1234, 1'b0, 0, 1'b0, 1'b0, "stable_1234");

    // Bit 3 disagrees on evaluations 0 and 2 only; it is set in three of five.
    base = 16'h123C ^ 16'hA5A5;
    for (int k = 0; k < NEV; k++) ev[k] = base;
    ev[0] = base ^ 16'h0008;
    ev[2] = base ^ 16'h0008;
    run_main(16'h123C, 1'b1, 0, 1'b0, 1'b0, "flip_bit3");

    // Consumer stalls 10 cycles in DONE; stray chal_valid pulses are ignored.
    run_main(16'($urandom), 1'b0, 10, 1'b0, 1'b1, "hold_done");

    // Back-to-back challenges with resp_ready tied high.
    run_main(16'h0001, 1'b0, 0, 1'b1, 1'b0, "b2b_0001");
    run_main(16'hFFFF, 1'b0, 0, 1'b1, 1'b0, "b2b_ffff");
    bus.resp_ready = 1'b0;

    // Random challenges against the stable array.
    for (int r = 0; r < 3; r++) run_main(16'($urandom), 1'b0, r, 1'b0, 1'b0, "rand_stable");

    // Random per-evaluation responses with sparse noise.
    for (int r = 0; r < 5; r++) begin
      base = 16'($urandom);
      for (int k = 0; k < NEV; k++) ev[k] = base ^ (16'($urandom) & 16'($urandom));
      run_main(16'($urandom), 1'b1, 1, 1'b0, 1'b0, "rand_noisy");
    end

    // Reset asserted in the first cycle of the third PULSE.
    bus.chal_valid = 1'b1;
    bus.chal_data  = 16'hBEEF;
    @(posedge clk); #1;
    bus.chal_valid = 1'b0;
    repeat (2 * T + S) begin
      @(posedge clk); #1;
    end
    check("midrst/pulse_before", dut.pulse_q, 1);
    rst_n = 1'b0;
    #1;
    check("midrst/pulse_drop", dut.pulse_q, 0);
    check("midrst/busy", bus.busy, 0);
    check("midrst/resp_valid", bus.resp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (L + 20) begin
      @(posedge clk); #1;
      if (bus.resp_valid) any_valid = 1'b1;
    end
    check("midrst/no_partial_resp", any_valid, 0);
    check("midrst/chal_ready", bus.chal_ready, 1);
    check("midrst/busy_after", bus.busy, 0);
    run_main(16'hC0DE, 1'b0, 0, 1'b0, 1'b0, "after_midrst");

    // Single-evaluation configuration.
    run_one(16'h1234, 1'b0, "neval1_stable");
    for (int r = 0; r < 3; r++) run_one(16'($urandom), 1'b1, "neval1_rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
